// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model: cycle-accurate plant model of an elevator car, shaft
// and door. Turns engine/door commands into the floor-level and door-state
// sensors a controller expects. Unsafe commands are refused and the first
// one is latched as a sticky fault code.
module elevator_shaft_model #(
   parameter int FLOORS        = 8,
   parameter int TRAVEL_CYCLES = 10,
   parameter int DOOR_CYCLES   = 8,
   parameter int INIT_POS      = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] engine,
   input  logic [1:0] door,
   output logic       sensor_up,
   output logic       sensor_down,
   output logic [1:0] sensor_door,
   output logic [3:0] position,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DW = $clog2(DOOR_CYCLES + 1);

   localparam logic [TW-1:0] TCNT_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DCNT_OPEN = DW'(DOOR_CYCLES);
   localparam logic [3:0]    TOP_POS   = 4'(2 * (FLOORS - 1));

   localparam logic [1:0] ST_PARKED    = 2'd0;
   localparam logic [1:0] ST_MOVE_UP   = 2'd1;
   localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
   localparam logic [1:0] ST_DOOR      = 2'd3;

   localparam logic [1:0] ENG_STOP = 2'b00;
   localparam logic [1:0] ENG_UP   = 2'b01;
   localparam logic [1:0] ENG_DOWN = 2'b10;
   localparam logic [1:0] DOOR_OPEN  = 2'b01;
   localparam logic [1:0] DOOR_CLOSE = 2'b10;

   logic [1:0]    state_reg, state_next;
   logic [3:0]    position_reg, position_next;
   logic [TW-1:0] tcnt_reg, tcnt_next;
   logic [DW-1:0] dcnt_reg, dcnt_next;
   logic          sensor_up_reg, sensor_up_next;
   logic          sensor_down_reg, sensor_down_next;
   logic [1:0]    sensor_door_reg, sensor_door_next;
   logic          fault_reg;
   logic [2:0]    fault_code_reg;

   logic [1:0] eng_cmd, door_cmd;
   logic       illegal, move_req, same_dir, going_up;
   logic       f_door_not_closed, f_door_unsafe, f_overtravel;
   logic       fault_now;
   logic [2:0] code_now;
   logic [DW-1:0] dcnt_inc, dcnt_dec;

   assign sensor_up   = sensor_up_reg;
   assign sensor_down = sensor_down_reg;
   assign sensor_door = sensor_door_reg;
   assign position    = position_reg;
   assign fault       = fault_reg;
   assign fault_code  = fault_code_reg;

   assign dcnt_inc = (dcnt_reg == DCNT_OPEN) ? dcnt_reg : dcnt_reg + 1'b1;
   assign dcnt_dec = (dcnt_reg == '0) ? dcnt_reg : dcnt_reg - 1'b1;

   // Command decode, FSM next state, motion/door counters and fault detection
   always_comb begin
      eng_cmd  = engine;
      door_cmd = door;
      illegal  = 1'b0;
      if (engine == 2'b11) begin
         eng_cmd = ENG_STOP;
         illegal = 1'b1;
      end
      if (door == 2'b11) begin
         door_cmd = 2'b00;
         illegal  = 1'b1;
      end
      move_req = (eng_cmd == ENG_UP) || (eng_cmd == ENG_DOWN);
      going_up = (state_reg == ST_MOVE_UP);
      same_dir = (eng_cmd == (going_up ? ENG_UP : ENG_DOWN));

      state_next        = state_reg;
      position_next     = position_reg;
      tcnt_next         = tcnt_reg;
      dcnt_next         = dcnt_reg;
      sensor_up_next    = 1'b0;
      sensor_down_next  = 1'b0;
      f_door_not_closed = move_req && (dcnt_reg != '0);
      f_door_unsafe     = 1'b0;
      f_overtravel      = 1'b0;

      case (state_reg)
         ST_PARKED: begin
            if (move_req && dcnt_reg == '0) begin
               state_next = (eng_cmd == ENG_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
               tcnt_next  = '0;
               if (door_cmd == DOOR_OPEN) f_door_unsafe = 1'b1;
            end else if (door_cmd == DOOR_OPEN) begin
               if (position_reg[0]) begin
                  f_door_unsafe = 1'b1;
               end else begin
                  state_next = ST_DOOR;
                  dcnt_next  = dcnt_inc;
               end
            end else if (door_cmd == DOOR_CLOSE) begin
               state_next = ST_DOOR;
               dcnt_next  = dcnt_dec;
            end
         end
         ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (door_cmd == DOOR_OPEN) f_door_unsafe = 1'b1;
            if (eng_cmd == ENG_STOP) begin
               state_next = ST_PARKED;
               tcnt_next  = '0;
            end else if (!same_dir) begin
               // reversal throws away the partial half-floor segment
               state_next = going_up ? ST_MOVE_DOWN : ST_MOVE_UP;
               tcnt_next  = '0;
            end else if (tcnt_reg == TCNT_LAST) begin
               tcnt_next = '0;
               if (going_up && position_reg == TOP_POS) begin
                  f_overtravel = 1'b1;
                  state_next   = ST_PARKED;
               end else if (!going_up && position_reg == 4'd0) begin
                  f_overtravel = 1'b1;
                  state_next   = ST_PARKED;
               end else if (going_up) begin
                  position_next  = position_reg + 4'd1;
                  sensor_up_next = position_reg[0];
               end else begin
                  position_next    = position_reg - 4'd1;
                  sensor_down_next = position_reg[0];
               end
            end else begin
               tcnt_next = tcnt_reg + 1'b1;
            end
         end
         default: begin // ST_DOOR
            if (dcnt_reg == '0 && door_cmd != DOOR_OPEN) begin
               state_next = ST_PARKED;
            end else if (door_cmd == DOOR_OPEN) begin
               if (position_reg[0]) f_door_unsafe = 1'b1;
               else dcnt_next = dcnt_inc;
            end else if (door_cmd == DOOR_CLOSE) begin
               dcnt_next = dcnt_dec;
            end
         end
      endcase

      fault_now = f_door_not_closed | f_door_unsafe | f_overtravel | illegal;
      if (f_door_not_closed)  code_now = 3'd1;
      else if (f_door_unsafe) code_now = 3'd2;
      else if (f_overtravel)  code_now = 3'd3;
      else if (illegal)       code_now = 3'd4;
      else                    code_now = 3'd0;

      if (dcnt_reg == '0)            sensor_door_next = 2'b10;
      else if (dcnt_reg == DCNT_OPEN) sensor_door_next = 2'b01;
      else                            sensor_door_next = 2'b00;
   end

   // State registers; the first fault seen is latched until reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= ST_PARKED;
         position_reg    <= 4'(INIT_POS);
         tcnt_reg        <= '0;
         dcnt_reg        <= '0;
         sensor_up_reg   <= 1'b0;
         sensor_down_reg <= 1'b0;
         sensor_door_reg <= 2'b10;
         fault_reg       <= 1'b0;
         fault_code_reg  <= 3'd0;
      end else begin
         state_reg       <= state_next;
         position_reg    <= position_next;
         tcnt_reg        <= tcnt_next;
         dcnt_reg        <= dcnt_next;
         sensor_up_reg   <= sensor_up_next;
         sensor_down_reg <= sensor_down_next;
         sensor_door_reg <= sensor_door_next;
         if (!fault_reg && fault_now) begin
            fault_reg      <= 1'b1;
            fault_code_reg <= code_now;
         end
      end
   end

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for elevator_shaft_model: a table of directed vectors, a few
// hand-written corner sequences, then randomized commands checked every
// cycle against a behavioural model of the car, shaft and door.
module tb_elevator_shaft_model;

   localparam int TC   = 10;
   localparam int DC   = 8;
   localparam int TOPP = 14;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] engine = 2'b00;
   logic [1:0] door = 2'b00;
   logic       sensor_up, sensor_down, fault;
   logic [1:0] sensor_door;
   logic [3:0] position;
   logic [2:0] fault_code;

   int tests = 0;
   int fails = 0;

   elevator_shaft_model #(.FLOORS(8), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .INIT_POS(0)) dut (
      .clk(clk), .reset(reset), .engine(engine), .door(door),
      .sensor_up(sensor_up), .sensor_down(sensor_down), .sensor_door(sensor_door),
      .position(position), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // mode: 0 parked, 1 moving, 2 door operating; dir is +1/-1 while moving
   int         m_pos = 0, m_prog = 0, m_lvl = 0, m_mode = 0, m_dir = 0;
   int         m_code = 0;
   bit         m_flt = 0, m_up = 0, m_dn = 0;
   logic [1:0] m_sd = 2'b10;

   always @(posedge clk) begin
      int e, d, want, worst, old_lvl, np;
      e = (engine == 2'b11) ? 0 : int'(engine);
      d = (door == 2'b11) ? 0 : int'(door);
      want = (e == 1) ? 1 : (e == 2) ? -1 : 0;
      worst = 99;
      old_lvl = m_lvl;
      m_up = 0;
      m_dn = 0;
      if (!reset) begin
         m_pos = 0; m_prog = 0; m_lvl = 0; m_mode = 0; m_dir = 0;
         m_flt = 0; m_code = 0; m_sd = 2'b10;
      end else begin
         if (engine == 2'b11 || door == 2'b11) worst = 4;
         if (want != 0 && m_lvl != 0) worst = 1;
         if (m_mode == 0) begin
            if (want != 0 && m_lvl == 0) begin
               m_mode = 1; m_dir = want; m_prog = 0;
               if (d == 1 && worst > 2) worst = 2;
            end else if (d == 1 && (m_pos % 2) == 1) begin
               if (worst > 2) worst = 2;
            end else if (d != 0) begin
               m_mode = 2;
               m_lvl = (d == 1) ? ((m_lvl + 1 > DC) ? DC : m_lvl + 1) : ((m_lvl > 0) ? m_lvl - 1 : 0);
            end
         end else if (m_mode == 1) begin
            if (d == 1 && worst > 2) worst = 2;
            if (want == 0) begin
               m_mode = 0; m_prog = 0;
            end else if (want != m_dir) begin
               m_dir = want; m_prog = 0;
            end else if (m_prog + 1 == TC) begin
               m_prog = 0;
               np = m_pos + m_dir;
               if (np < 0 || np > TOPP) begin
                  if (worst > 3) worst = 3;
                  m_mode = 0;
               end else begin
                  m_pos = np;
                  if (np % 2 == 0) begin
                     if (m_dir > 0) m_up = 1; else m_dn = 1;
                  end
               end
            end else begin
               m_prog = m_prog + 1;
            end
         end else begin
            if (m_lvl == 0 && d != 1) m_mode = 0;
            else if (d == 1) m_lvl = (m_lvl + 1 > DC) ? DC : m_lvl + 1;
            else if (d == 2) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
         end
         m_sd = (old_lvl == 0) ? 2'b10 : (old_lvl == DC) ? 2'b01 : 2'b00;
         if (!m_flt && worst != 99) begin
            m_flt = 1;
            m_code = worst;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive a command for n cycles, counting floor-level pulses seen
   task automatic run(input bit rst, input logic [1:0] e_cmd, input logic [1:0] d_cmd,
                      input int n, output int ups, output int downs);
      reset  = !rst;
      engine = e_cmd;
      door   = d_cmd;
      ups = 0;
      downs = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         ups   += int'(sensor_up);
         downs += int'(sensor_down);
      end
   endtask

   typedef struct {
      string      name;
      bit         rst;
      logic [1:0] eng;
      logic [1:0] dr;
      int         cycles;
      int         pos;
      logic [1:0] sd;
      bit         flt;
      int         code;
      int         ups;
      int         downs;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string name, bit rst, logic [1:0] eng, logic [1:0] dr, int cycles,
                               int pos, logic [1:0] sd, bit flt, int code, int ups, int downs);
      vec_t v;
      v.name = name; v.rst = rst; v.eng = eng; v.dr = dr; v.cycles = cycles;
      v.pos = pos; v.sd = sd; v.flt = flt; v.code = code; v.ups = ups; v.downs = downs;
      vecs.push_back(v);
   endfunction

   initial begin
      int u, dn, n;
      logic [1:0] re, rd;
      bit rr;

      // name, rst, eng, door, cycles -> pos, sensor_door, fault, code, ups, downs
      add("reset",          1, 2'b00, 2'b00,   3,  0, 2'b10, 0, 0, 0, 0);
      add("half_floor",     0, 2'b01, 2'b00,  11,  1, 2'b10, 0, 0, 0, 0);
      add("floor_up",       0, 2'b01, 2'b00,  10,  2, 2'b10, 0, 0, 1, 0);
      add("stop_at_2",      0, 2'b00, 2'b00,   1,  2, 2'b10, 0, 0, 0, 0);
      add("door_first",     0, 2'b00, 2'b01,   1,  2, 2'b10, 0, 0, 0, 0);
      add("door_transit",   0, 2'b00, 2'b01,   7,  2, 2'b00, 0, 0, 0, 0);
      add("door_open",      0, 2'b00, 2'b01,   1,  2, 2'b01, 0, 0, 0, 0);
      add("door_hold",      0, 2'b00, 2'b00,   3,  2, 2'b01, 0, 0, 0, 0);
      add("door_closing",   0, 2'b00, 2'b10,   8,  2, 2'b00, 0, 0, 0, 0);
      add("door_closed",    0, 2'b00, 2'b10,   1,  2, 2'b10, 0, 0, 0, 0);
      add("door_reopen",    0, 2'b00, 2'b01,   9,  2, 2'b01, 0, 0, 0, 0);
      add("move_door_open", 0, 2'b10, 2'b00,  30,  2, 2'b01, 1, 1, 0, 0);
      add("reset2",         1, 2'b00, 2'b00,   2,  0, 2'b10, 0, 0, 0, 0);
      add("up_to_5",        0, 2'b01, 2'b00,  51,  5, 2'b10, 0, 0, 2, 0);
      add("stop_at_5",      0, 2'b00, 2'b00,   1,  5, 2'b10, 0, 0, 0, 0);
      add("open_odd",       0, 2'b00, 2'b01,   3,  5, 2'b10, 1, 2, 0, 0);
      add("reset3",         1, 2'b00, 2'b00,   2,  0, 2'b10, 0, 0, 0, 0);
      add("up_to_top",      0, 2'b01, 2'b00, 141, 14, 2'b10, 0, 0, 7, 0);
      add("overtravel",     0, 2'b01, 2'b00,  10, 14, 2'b10, 1, 3, 0, 0);
      add("park_top",       0, 2'b00, 2'b00,   1, 14, 2'b10, 1, 3, 0, 0);
      add("down_partial",   0, 2'b10, 2'b00,   5, 14, 2'b10, 1, 3, 0, 0);
      add("reset_mid_move", 1, 2'b10, 2'b00,   1,  0, 2'b10, 0, 0, 0, 0);
      add("after_reset",    0, 2'b00, 2'b00,   2,  0, 2'b10, 0, 0, 0, 0);
      add("up_to_2",        0, 2'b01, 2'b00,  21,  2, 2'b10, 0, 0, 1, 0);
      add("up_partial",     0, 2'b01, 2'b00,   5,  2, 2'b10, 0, 0, 0, 0);
      add("reverse_full",   0, 2'b10, 2'b00,  10,  2, 2'b10, 0, 0, 0, 0);
      add("reverse_step",   0, 2'b10, 2'b00,   1,  1, 2'b10, 0, 0, 0, 0);
      add("down_to_0",      0, 2'b10, 2'b00,  10,  0, 2'b10, 0, 0, 0, 1);
      add("park_0",         0, 2'b00, 2'b00,   1,  0, 2'b10, 0, 0, 0, 0);
      add("illegal_engine", 0, 2'b11, 2'b00,   5,  0, 2'b10, 1, 4, 0, 0);

      foreach (vecs[i]) begin
         run(vecs[i].rst, vecs[i].eng, vecs[i].dr, vecs[i].cycles, u, dn);
         check({vecs[i].name, ".position"},    int'(position),    vecs[i].pos);
         check({vecs[i].name, ".sensor_door"}, int'(sensor_door), int'(vecs[i].sd));
         check({vecs[i].name, ".fault"},       int'(fault),       int'(vecs[i].flt));
         check({vecs[i].name, ".fault_code"},  int'(fault_code),  vecs[i].code);
         check({vecs[i].name, ".up_pulses"},   u,                 vecs[i].ups);
         check({vecs[i].name, ".down_pulses"}, dn,                vecs[i].downs);
         $display("[TB] vec %s: pos=%0d sd=%b fault=%0b code=%0d up=%0d down=%0d",
                  vecs[i].name, position, sensor_door, fault, fault_code, u, dn);
      end

      // simultaneous move and door-open while parked: move wins, door refused
      run(1, 2'b00, 2'b00, 2, u, dn);
      run(0, 2'b01, 2'b01, 1, u, dn);
      check("simul.fault_code", int'(fault_code), 2);
      check("simul.sensor_door", int'(sensor_door), 2);
      run(0, 2'b01, 2'b00, 10, u, dn);
      check("simul.position", int'(position), 1);
      $display("[TB] seq simul: pos=%0d code=%0d", position, fault_code);

      // reset while the door is part-open forces it closed
      run(1, 2'b00, 2'b00, 2, u, dn);
      run(0, 2'b00, 2'b01, 4, u, dn);
      check("rst_door.transit", int'(sensor_door), 0);
      run(1, 2'b00, 2'b01, 1, u, dn);
      check("rst_door.reset", int'(sensor_door), 2);
      run(0, 2'b00, 2'b00, 1, u, dn);
      check("rst_door.closed", int'(sensor_door), 2);
      check("rst_door.fault", int'(fault), 0);
      $display("[TB] seq rst_door: sd=%b fault=%0b", sensor_door, fault);

      // moving down from the bottom floor clamps
      run(0, 2'b10, 2'b00, 11, u, dn);
      check("under.position", int'(position), 0);
      check("under.fault_code", int'(fault_code), 3);
      check("under.down_pulses", dn, 0);
      $display("[TB] seq under: pos=%0d code=%0d", position, fault_code);

      // illegal door encoding
      run(1, 2'b00, 2'b00, 2, u, dn);
      run(0, 2'b00, 2'b11, 2, u, dn);
      check("door11.fault_code", int'(fault_code), 4);
      check("door11.sensor_door", int'(sensor_door), 2);
      $display("[TB] seq door11: sd=%b code=%0d", sensor_door, fault_code);

      // randomized command segments checked every cycle against the model
      run(1, 2'b00, 2'b00, 2, u, dn);
      for (int s = 0; s < 150; s++) begin
         int r;
         rr = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 19);
         re = (r < 7) ? 2'b00 : (r < 13) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
         r = $urandom_range(0, 19);
         if (re != 2'b00 && r < 17) rd = 2'b00;
         else rd = (r < 6) ? 2'b00 : (r < 12) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
         n = rr ? $urandom_range(1, 2) : $urandom_range(1, 40);
         reset = !rr;
         engine = re;
         door = rd;
         for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (int'(position) != m_pos || sensor_up != m_up || sensor_down != m_dn ||
                sensor_door != m_sd || fault != m_flt || int'(fault_code) != m_code) begin
               fails++;
               $display("[TB] FAIL rand seg %0d cyc %0d: got pos=%0d up=%0b dn=%0b sd=%b f=%0b code=%0d expected pos=%0d up=%0b dn=%0b sd=%b f=%0b code=%0d",
                        s, c, position, sensor_up, sensor_down, sensor_door, fault, fault_code,
                        m_pos, m_up, m_dn, m_sd, m_flt, m_code);
            end
         end
         $display("[TB] rand seg %0d: rst=%0b eng=%b door=%b cycles=%0d pos=%0d sd=%b code=%0d",
                  s, rr, re, rd, n, position, sensor_door, fault_code);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
